wg_wid_unit: RTL

- Parametrised WorldGuard world-ID (WID) unit for the CVA6 core.
- Holds the machine-, supervisor- and virtual-supervisor WID registers and the M-mode delegation mask.
- Computes the effective WID from the current privilege level and virtualisation state.
- Tags outgoing memory requests with that WID through a one-entry register slice. It fences a WID change until all outstanding requests tagged with the old WID have completed.

---
 rtl/wg_wid_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wg_wid_unit.sv
// WorldGuard world-ID unit: WID CSRs, effective-WID selection and a one-entry
// request slice that tags requests and fences WID changes until the old world drains.
module wg_wid_unit #(
    parameter int unsigned NrWorlds       = 128,
    parameter bit          SSWGEn         = 1'b1,
    parameter bit          SHWGEn         = 1'b1,
    parameter int unsigned ResetMlwid     = NrWorlds - 1,
    parameter int unsigned MaxOutstanding = 7,
    parameter int unsigned PayloadWidth   = 64,
    localparam int unsigned WidW          = $clog2(NrWorlds),
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    csr_we_i,
    input  logic [1:0]              csr_addr_i,
    input  logic [NrWorlds-1:0]     csr_wdata_i,
    output logic [NrWorlds-1:0]     csr_rdata_o,
    output logic                    csr_illegal_o,
    input  logic [1:0]              priv_i,
    input  logic                    v_i,
    output logic [WidW-1:0]         wid_o,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [PayloadWidth-1:0] req_payload_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [PayloadWidth-1:0] req_payload_o,
    output logic [WidW-1:0]         req_wid_o,
    input  logic                    rsp_valid_i,
    output logic [CntW-1:0]         outstanding_o,
    output logic                    fence_o,
    output logic                    err_underflow_o
);

    localparam logic [1:0]          AddrMlwid     = 2'd0;
    localparam logic [1:0]          AddrSlwid     = 2'd1;
    localparam logic [1:0]          AddrMwiddeleg = 2'd2;
    localparam logic [1:0]          AddrVslwid    = 2'd3;
    localparam logic [1:0]          PrivM         = 2'd3;
    localparam logic [WidW-1:0]     RstWid        = WidW'(ResetMlwid);
    localparam logic [NrWorlds-1:0] NrWorldsExt   = NrWorlds'(NrWorlds);
    localparam logic [CntW:0]       MaxOut        = (CntW + 1)'(MaxOutstanding);

    logic [WidW-1:0]     mlwid, slwid, vslwid, last_wid;
    logic [NrWorlds-1:0] mwiddeleg;
    logic [CntW-1:0]     outstanding;
    logic                deleg_ok, wid_ok, accept, handshake;

    assign deleg_ok = mwiddeleg[csr_wdata_i[WidW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mlwid     <= RstWid;
            slwid     <= RstWid;
            vslwid    <= RstWid;
            mwiddeleg <= '0;
        end else if (csr_we_i) begin
            unique case (csr_addr_i)
                AddrMlwid:     if (csr_wdata_i < NrWorldsExt) mlwid <= csr_wdata_i[WidW-1:0];
                AddrSlwid:     if (SSWGEn && deleg_ok) slwid <= csr_wdata_i[WidW-1:0];
                AddrMwiddeleg: mwiddeleg <= csr_wdata_i;
                AddrVslwid:    if (SHWGEn && deleg_ok) vslwid <= csr_wdata_i[WidW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata_o   = '0;
        csr_illegal_o = 1'b0;
        unique case (csr_addr_i)
            AddrMlwid:     csr_rdata_o = NrWorlds'(mlwid);
            AddrSlwid: begin
                csr_illegal_o = !SSWGEn;
                if (SSWGEn) csr_rdata_o = NrWorlds'(slwid);
            end
            AddrMwiddeleg: csr_rdata_o = mwiddeleg;
            AddrVslwid: begin
                csr_illegal_o = !SHWGEn;
                if (SHWGEn) csr_rdata_o = NrWorlds'(vslwid);
            end
            default: ;
        endcase
    end

    always_comb begin
        if (priv_i == PrivM)     wid_o = mlwid;
        else if (v_i && SHWGEn)  wid_o = vslwid;
        else if (SSWGEn)         wid_o = slwid;
        else                     wid_o = mlwid;
    end

    // A new WID may only issue once every request tagged with the old one has left.
    assign wid_ok      = ((outstanding == '0) && !req_valid_o) || (wid_o == last_wid);
    assign fence_o     = !wid_ok;
    assign req_ready_o = wid_ok && (!req_valid_o || req_ready_i)
                         && (({1'b0, outstanding} + (CntW + 1)'(req_valid_o)) < MaxOut);
    assign accept      = req_valid_i && req_ready_o;
    assign handshake   = req_valid_o && req_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_o   <= 1'b0;
            req_payload_o <= '0;
            req_wid_o     <= '0;
            last_wid      <= RstWid;
        end else if (accept) begin
            req_valid_o   <= 1'b1;
            req_payload_o <= req_payload_i;
            req_wid_o     <= wid_o;
            last_wid      <= wid_o;
        end else if (handshake) begin
            req_valid_o   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding     <= '0;
            err_underflow_o <= 1'b0;
        end else if (handshake && !rsp_valid_i) begin
            outstanding <= outstanding + 1'b1;
        end else if (!handshake && rsp_valid_i) begin
            if (outstanding == '0) err_underflow_o <= 1'b1;
            else                   outstanding     <= outstanding - 1'b1;
        end
    end

    assign outstanding_o = outstanding;

endmodule
